// File: rtl/snake_pkg.sv
// Shared snake-game types: one-hot direction encoding and the reverse-direction helper
// used by both the direction front end and the movement logic.
package snake_pkg;

    typedef logic [3:0] dir_t;

    localparam dir_t DIR_NONE  = 4'b0000;
    localparam dir_t DIR_LEFT  = 4'b0001;
    localparam dir_t DIR_RIGHT = 4'b0010;
    localparam dir_t DIR_DOWN  = 4'b0100;
    localparam dir_t DIR_UP    = 4'b1000;

    // Opposite heading; NONE (or any non-one-hot value) has no opposite.
    function automatic dir_t dir_reverse(input dir_t dir);
        dir_t rev;
        case (dir)
            DIR_LEFT:  rev = DIR_RIGHT;
            DIR_RIGHT: rev = DIR_LEFT;
            DIR_DOWN:  rev = DIR_UP;
            DIR_UP:    rev = DIR_DOWN;
            default:   rev = DIR_NONE;
        endcase
        return rev;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One push-button front end: 2-FF synchroniser, stable-level debounce counter and a
// registered one-cycle press pulse on the rising edge of the debounced level.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             stable_last_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it
    // holding its old value and no latch is inferred.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values;
    // reset is synchronous and active-low, so it is just the first branch inside the clocked block.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_last_q <= 1'b0;
            cnt_q         <= '0;
            press_q       <= 1'b0;
        end else begin
            sync1_q       <= btn_i;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_last_q <= stable_q;
            cnt_q         <= cnt_d;
            press_q       <= stable_q & ~stable_last_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/direction_input.sv
// Snake direction front end: debounced buttons -> latest-wins pending request -> one
// committed one-hot direction per move_tick. Define DIR_REVERSE_BLOCK_EN to reject U-turns.
module direction_input
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       l,
    input  logic       r,
    input  logic       u,
    input  logic       d,
    input  logic       move_tick,
    output logic [3:0] direction,
    output logic       turn
);

    // Button vector laid out in the same bit order as the one-hot direction code.
    logic [3:0] btn_raw;
    logic [3:0] press;

    assign btn_raw = {u, d, r, l};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .btn_i  (btn_raw[i]),
            .press_o(press[i])
        );
    end

    dir_t event_dir;
    dir_t candidate;
    dir_t pending_q, pending_d;
    dir_t dir_q, dir_d;
    logic turn_q, turn_d;

    always_comb begin
        event_dir = DIR_NONE;
        if (press[0])      event_dir = DIR_LEFT;
        else if (press[1]) event_dir = DIR_RIGHT;
        else if (press[3]) event_dir = DIR_UP;
        else if (press[2]) event_dir = DIR_DOWN;
    end

    // A press in the tick cycle bypasses pending and is consumed by that tick.
    assign candidate = (event_dir != DIR_NONE) ? event_dir : pending_q;

    always_comb begin
        pending_d = pending_q;
        dir_d     = dir_q;
        turn_d    = 1'b0;
        if (move_tick) begin
            pending_d = DIR_NONE;
            if (candidate != DIR_NONE && candidate != dir_q) begin
`ifdef DIR_REVERSE_BLOCK_EN
                if (candidate != dir_reverse(dir_q)) begin
                    dir_d  = candidate;
                    turn_d = 1'b1;
                end
`else
                dir_d  = candidate;
                turn_d = 1'b1;
`endif
            end
        end else if (event_dir != DIR_NONE) begin
            pending_d = event_dir;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q <= DIR_NONE;
            dir_q     <= DIR_NONE;
            turn_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            dir_q     <= dir_d;
            turn_q    <= turn_d;
        end
    end

    assign direction = dir_q;
    assign turn      = turn_q;

endmodule

// File: doc/direction_input.md
# direction_input

Front-end control stage of the snake game. It synchronises and debounces the four push-buttons and turns presses into direction requests. It holds each request until the next snake move tick, then commits it as the one-hot `direction` word that the snake movement logic consumes on each update. Committing once per tick means the snake can turn at most once per move and can never fold back onto itself.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable `clk` cycles required to accept a button level change (10 ms at 100 MHz).
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `l`, `r`, `u`, `d`  in  1 each  raw asynchronous buttons, active-high.
- `move_tick`  in  1  one-cycle pulse in the `clk` domain, issued once per snake move.
- `direction`  out  4  committed direction, one-hot, registered.
- `turn`  out  1  one-cycle pulse when `direction` changes.

## Operation
- Direction encoding:
  - 0000 NONE (stationary)
  - 0001 LEFT (x−10)
  - 0010 RIGHT (x+10)
  - 0100 DOWN (y−10)
  - 1000 UP (y+10)
- Synchroniser: 2-FF synchroniser per button.
- Debounce, per button:
  - State: `stable` and a counter.
  - If synced ≠ `stable`: the counter increments. When it reaches `DEBOUNCE_CYCLES−1`, `stable` flips and the counter clears.
  - If synced = `stable`: the counter clears.
  - Saturating arithmetic, no wrap.
- Press event: rising edge of `stable` only. Release events are ignored.
- Simultaneous press events in one cycle: priority LEFT > RIGHT > UP > DOWN; one event is kept.
- Pending register: a 4-bit one-hot `pending`.
  - A new event overwrites `pending`, so the latest press wins.
  - `pending` clears on every `move_tick`, whether or not the request was committed.
- Commit on `move_tick`:
  - Candidate is the current-cycle event if present, else `pending`.
  - Candidate NONE: `direction` is unchanged.
  - Candidate equal to `direction`: no change and no `turn`.
  - Candidate is the reverse of `direction` (LEFT↔RIGHT, UP↔DOWN): rejected (see Configuration).
  - Otherwise `direction` takes the candidate and `turn`=1 for one cycle.
  - From NONE, any direction is accepted.
- Reset (`reset`=0) clears everything at the next edge:
  - `direction`=0000, `turn`=0, `pending`=0.
  - All counters 0, all `stable` 0, synchronisers 0.
- Reset mid-debounce or with a request pending discards all progress. A button held through reset produces a new press event once it is re-debounced after release of reset.

## Timing
- Pin change to `stable` flip: 2 + `DEBOUNCE_CYCLES` cycles.
- Press event appears 1 cycle after the `stable` flip.
- `direction` and `turn` update on the edge that samples `move_tick`=1, visible the following cycle.
- An event in the same cycle as `move_tick` is committed on that tick (bypass). It is not also retained in `pending`.
- `move_tick` asserted for consecutive cycles: each cycle is treated as a separate tick.
- Maximum of one direction change per tick.

## Configuration
- `DIR_REVERSE_BLOCK_EN`:
  - Defined: reverse candidates are discarded and `direction` holds.
  - Undefined: reverse candidates are committed like any other change, with a `turn` pulse. This setting is for debug and bring-up only.

## Structure
- Shared package `snake_pkg`:
  - Constants `DIR_NONE`, `DIR_LEFT`, `DIR_RIGHT`, `DIR_DOWN`, `DIR_UP` (4-bit).
  - Typedef `dir_t` (`logic [3:0]`).
  - Function `dir_reverse(dir_t)`, also used by the movement logic.
- Sub-module `button_debounce` (synchroniser + counter + rising-edge detect) instantiated four times. The top level holds the priority encoder, `pending` and the commit logic.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset, then hold `r`=1 for 10 cycles, then one `move_tick`: `direction`=0010 and `turn`=1 for exactly 1 cycle.
- Glitch on `u` of 3 cycles high, then `move_tick`: `direction` unchanged, `turn`=0.
- With `direction`=0010, press `l`, then `move_tick`:
  - With `DIR_REVERSE_BLOCK_EN`: stays 0010, `turn`=0.
  - Without: becomes 0001 with a `turn` pulse.
- With `direction`=0010, press `u` then `d` before one tick: commits 0100 (latest wins). A second tick with no press keeps 0100.
- `l` and `u` debounce in the same cycle from NONE, then tick: `direction`=0001.
- Assert `reset`=0 while `pending`=1000 and a counter is mid-count: all outputs are 0 after the next edge, and the following `move_tick` leaves `direction`=0000.
